fifo_sram_writer: RTL and testbench

FIFO_SRAM_WRITER -- requirements
Module: fifo_sram_writer

---
 rtl/fsw_pkg.sv | 19 +
 rtl/fsw_ack_timer.sv | 32 +++
 rtl/fifo_sram_writer.sv | 134 +++++++++++++
 tb/tb_fifo_sram_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsw_pkg.sv
// Shared definitions for the FIFO-to-SRAM writer: FSM encoding and ack-timeout constants.
// No logic; latency n/a.
// Backpressure n/a.
package fsw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fsw_state_e;

    localparam int FSW_TIMEOUT_CYCLES = 255;
    localparam int FSW_TIMER_WIDTH    = $clog2(FSW_TIMEOUT_CYCLES);

    localparam logic [FSW_TIMER_WIDTH-1:0] FSW_TIMER_LAST =
        FSW_TIMER_WIDTH'(FSW_TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/fsw_ack_timer.sv
// Counts cycles spent waiting for an SRAM ack; flags expiry on the last allowed cycle.
// Expiry is combinational from the count register, so it lands on the 255th waiting cycle.
// No backpressure; the count clears whenever run_i drops.
module fsw_ack_timer
    import fsw_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic run_i,
    output logic expired_o
);

    logic [FSW_TIMER_WIDTH-1:0] cnt_q, cnt_d;

    assign expired_o = run_i && (cnt_q == FSW_TIMER_LAST);

    always_comb begin
        cnt_d = '0;
        if (run_i && !expired_o) begin
            cnt_d = cnt_q + {{(FSW_TIMER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_sram_writer.sv
// Moves word_count words from an upstream FIFO to consecutive SRAM addresses; FSW_ACK_TIMEOUT_EN adds an ack timeout.
// Latency: 2 cycles per word minimum (FETCH pops, WRITE holds req until ack), plus one DONE cycle.
// Backpressure: stalls in FETCH while the FIFO is empty and in WRITE until sram_ack_i.
module fifo_sram_writer
    import fsw_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int COUNT_WIDTH     = 13
) (
    input  logic                       fsw_clk_i,
    input  logic                       fsw_rstn_i,
    input  logic                       start_i,
    input  logic [SRAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [COUNT_WIDTH-1:0]     word_count_i,
    input  logic                       fifo_emptyflag_i,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_readdata_i,
    output logic                       fifo_readflag_o,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [FIFO_DATA_WIDTH-1:0] sram_data_o,
    input  logic                       sram_ack_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [COUNT_WIDTH-1:0]     remaining_o
);

    localparam logic [COUNT_WIDTH-1:0]     CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    fsw_state_e                 state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FIFO_DATA_WIDTH-1:0] data_q, data_d;
    logic [COUNT_WIDTH-1:0]     rem_q, rem_d;
    logic                       timeout;

`ifdef FSW_ACK_TIMEOUT_EN
    logic error_q, error_d;

    fsw_ack_timer u_ack_timer (
        .clk_i     (fsw_clk_i),
        .rstn_i    (fsw_rstn_i),
        .run_i     (state_q == ST_WRITE),
        .expired_o (timeout)
    );

    // Sticky until the next accepted start; a same-cycle ack beats the timeout.
    always_comb begin
        error_d = error_q;
        if (state_q == ST_IDLE && start_i) begin
            error_d = 1'b0;
        end else if (timeout && !sram_ack_i) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge fsw_clk_i or negedge fsw_rstn_i) begin
        if (!fsw_rstn_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    // Outputs decode from state_q so the async reset clears them immediately.
    assign fifo_readflag_o = (state_q == ST_FETCH) && !fifo_emptyflag_i;
    assign sram_req_o      = (state_q == ST_WRITE);
    assign sram_we_o       = (state_q == ST_WRITE);
    assign sram_addr_o     = addr_q;
    assign sram_data_o     = data_q;
    assign busy_o          = (state_q == ST_FETCH) || (state_q == ST_WRITE);
    assign done_o          = (state_q == ST_DONE);
    assign remaining_o     = rem_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    rem_d   = word_count_i;
                    state_d = (word_count_i == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_emptyflag_i) begin
                    data_d  = fifo_readdata_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sram_ack_i) begin
                    addr_d  = addr_q + ADDR_ONE;
                    rem_d   = rem_q - CNT_ONE;
                    state_d = (rem_q == CNT_ONE) ? ST_DONE : ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fsw_clk_i or negedge fsw_rstn_i) begin
        if (!fsw_rstn_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_fifo_sram_writer.sv
// Directed scoreboard bench for fifo_sram_writer with a behavioural FIFO on its read side.
module tb_fifo_sram_writer;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int CW = 13;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [CW-1:0] wcnt = '0;
    logic          empty;
    logic [DW-1:0] rdata;
    logic          rflag, req, we, ack, busy, done, err;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdata;
    logic [CW-1:0] rem;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int req_cyc  = 0;
    int done_cnt = 0;
    int writes   = 0;
    int fetch_cyc = 0;
    int done_cyc  = 0;

    wr_t exp_q[$];

    logic [DW-1:0] fifo_q[$];
    int            fifo_cnt = 0;
    logic [DW-1:0] push_dat[64];
    int            push_wr = 0;
    int            flush_wr = 0;

    fifo_sram_writer #(.FIFO_DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .fsw_clk_i        (clk),
        .fsw_rstn_i       (rstn),
        .start_i          (start),
        .base_addr_i      (base),
        .word_count_i     (wcnt),
        .fifo_emptyflag_i (empty),
        .fifo_readdata_i  (rdata),
        .fifo_readflag_o  (rflag),
        .sram_req_o       (req),
        .sram_we_o        (we),
        .sram_addr_o      (saddr),
        .sram_data_o      (sdata),
        .sram_ack_i       (ack),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (err),
        .remaining_o      (rem)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks = n_checks + 1;
        if (act !== expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Behavioural FIFO: pops on a readflag seen mid-cycle, then absorbs queued pushes/flushes.
    initial begin
        logic pop;
        int   push_rd;
        int   flush_rd;
        push_rd  = 0;
        flush_rd = 0;
        empty    = 1'b1;
        rdata    = '0;
        forever begin
            @(negedge clk);
            pop = rflag;
            @(posedge clk);
            #1;
            if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (flush_rd != flush_wr) begin
                fifo_q.delete();
                flush_rd = flush_wr;
            end
            while (push_rd < push_wr) begin
                fifo_q.push_back(push_dat[push_rd]);
                push_rd = push_rd + 1;
            end
            fifo_cnt = fifo_q.size();
            empty    = (fifo_cnt == 0);
            rdata    = (fifo_cnt > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: scoreboard compare on every accepted SRAM write plus protocol checks.
    initial begin
        logic prev_acc;
        logic busy_prev;
        wr_t  e;
        prev_acc  = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (rflag) begin
                    pops = pops + 1;
                    chk("pop_only_when_nonempty", {63'd0, empty}, 64'd0);
                end
                if (prev_acc) chk("req_low_after_ack", {63'd0, req}, 64'd0);
                if (req) req_cyc = req_cyc + 1;
                if (busy && !busy_prev) fetch_cyc = cyc;
                if (done) begin
                    done_cnt = done_cnt + 1;
                    done_cyc = cyc;
                end
                if (req && ack) begin
                    writes = writes + 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_addr", 64'(saddr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(saddr), 64'(e.a));
                        chk("wr_data", 64'(sdata), 64'(e.d));
                        chk("wr_we", {63'd0, we}, 64'd1);
                    end
                end
                prev_acc  = req && ack;
                busy_prev = busy;
            end else begin
                prev_acc  = 1'b0;
                busy_prev = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push_dat[push_wr] = d;
        push_wr = push_wr + 1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        base  = b;
        wcnt  = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n = n + 1;
        end
        chk(name, {63'd0, done_cnt != d0}, 64'd1);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (!req && n < budget) begin
            tick(1);
            n = n + 1;
        end
        chk(name, {63'd0, req}, 64'd1);
    endtask

    initial begin
        int p0;
        int r0;
        int d0;
        int w0;
        ack = 1'b1;

        // Reset state
        #3;
        chk("rst_req",   {63'd0, req},   64'd0);
        chk("rst_rflag", {63'd0, rflag}, 64'd0);
        chk("rst_busy",  {63'd0, busy},  64'd0);
        chk("rst_done",  {63'd0, done},  64'd0);
        chk("rst_err",   {63'd0, err},   64'd0);
        chk("rst_addr",  64'(saddr), 64'd0);
        chk("rst_data",  64'(sdata), 64'd0);
        chk("rst_rem",   64'(rem),   64'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Case 1: preloaded FIFO, immediate ack
        for (int i = 0; i < 4; i++) begin
            push_word(32'hA0 + 32'(i));
            expect_wr(18'h00100 + 18'(i), 32'hA0 + 32'(i));
        end
        tick(3);
        chk("c1_fifo_loaded", 64'(fifo_cnt), 64'd4);
        p0 = pops; r0 = req_cyc; d0 = done_cnt;
        do_start(18'h00100, 13'd4);
        wait_done("c1_done_seen", 40);
        chk("c1_pops",    64'(pops - p0),     64'd4);
        chk("c1_reqs",    64'(req_cyc - r0),  64'd4);
        chk("c1_dones",   64'(done_cnt - d0), 64'd1);
        chk("c1_latency", 64'(done_cyc - fetch_cyc), 64'd8);
        chk("c1_rem",     64'(rem),           64'd0);
        chk("c1_sb_empty", 64'(exp_q.size()), 64'd0);
        tick(2);
        chk("c1_fifo_drained", 64'(fifo_cnt), 64'd0);

        // Case 2: FIFO empty for 10 cycles before each word
        p0 = pops; r0 = req_cyc;
        do_start(18'h00200, 13'd3);
        for (int i = 0; i < 3; i++) begin
            tick(10);
            chk("c2_rem_live", 64'(rem), 64'(3 - i));
            chk("c2_busy_wait", {63'd0, busy}, 64'd1);
            chk("c2_no_req_empty", {63'd0, req}, 64'd0);
            push_word(32'hB0 + 32'(i));
            expect_wr(18'h00200 + 18'(i), 32'hB0 + 32'(i));
        end
        wait_done("c2_done_seen", 40);
        chk("c2_pops", 64'(pops - p0),    64'd3);
        chk("c2_reqs", 64'(req_cyc - r0), 64'd3);
        chk("c2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Case 3: address wrap
        push_word(32'hC0);
        push_word(32'hC1);
        expect_wr(18'h3FFFF, 32'hC0);
        expect_wr(18'h00000, 32'hC1);
        tick(3);
        do_start(18'h3FFFF, 13'd2);
        wait_done("c3_done_seen", 40);
        chk("c3_sb_empty", 64'(exp_q.size()), 64'd0);
        tick(2);

        // Case 4a: zero-length transfer
        p0 = pops; r0 = req_cyc; d0 = done_cnt;
        base  = 18'h00050;
        wcnt  = 13'd0;
        start = 1'b1;
        @(negedge clk);
        chk("c4_done_not_early", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("c4_done_next_cycle", {63'd0, done}, 64'd1);
        chk("c4_not_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("c4_done_one_cycle", {63'd0, done}, 64'd0);
        tick(1);
        chk("c4_pops",  64'(pops - p0),     64'd0);
        chk("c4_reqs",  64'(req_cyc - r0),  64'd0);
        chk("c4_dones", 64'(done_cnt - d0), 64'd1);

        // Case 4b: start while busy is ignored
        p0 = pops; d0 = done_cnt;
        do_start(18'h00300, 13'd1);
        tick(3);
        do_start(18'h00010, 13'd5);
        chk("c4_rem_unchanged", 64'(rem), 64'd1);
        push_word(32'hD0);
        expect_wr(18'h00300, 32'hD0);
        wait_done("c4b_done_seen", 40);
        tick(3);
        chk("c4b_pops",  64'(pops - p0),     64'd1);
        chk("c4b_dones", 64'(done_cnt - d0), 64'd1);
        chk("c4b_idle",  {63'd0, busy},      64'd0);
        chk("c4b_sb_empty", 64'(exp_q.size()), 64'd0);

        // Case 5: reset while word 2 of 5 is pending
        ack = 1'b0;
        w0 = writes;
        for (int i = 0; i < 5; i++) push_word(32'hE0 + 32'(i));
        expect_wr(18'h00400, 32'hE0);
        tick(3);
        do_start(18'h00400, 13'd5);
        wait_req("c5_req1", 20);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        wait_req("c5_req2", 20);
        tick(2);
        rstn = 1'b0;
        #1;
        chk("c5_rst_req",   {63'd0, req},   64'd0);
        chk("c5_rst_we",    {63'd0, we},    64'd0);
        chk("c5_rst_rflag", {63'd0, rflag}, 64'd0);
        chk("c5_rst_busy",  {63'd0, busy},  64'd0);
        chk("c5_rst_addr",  64'(saddr),     64'd0);
        chk("c5_rst_data",  64'(sdata),     64'd0);
        chk("c5_rst_rem",   64'(rem),       64'd0);
        tick(2);
        rstn = 1'b1;
        ack  = 1'b1;
        tick(3);
        chk("c5_fifo_keeps3", 64'(fifo_cnt), 64'd3);
        chk("c5_writes", 64'(writes - w0), 64'd1);
        chk("c5_idle", {63'd0, busy}, 64'd0);
        chk("c5_sb_empty", 64'(exp_q.size()), 64'd0);
        flush_wr = flush_wr + 1;
        tick(3);

`ifdef FSW_ACK_TIMEOUT_EN
        // Case 6: ack withheld, timeout path
        ack = 1'b0;
        r0 = req_cyc; d0 = done_cnt; w0 = writes;
        push_word(32'hF0);
        tick(3);
        do_start(18'h00500, 13'd1);
        wait_done("c6_done_seen", 400);
        chk("c6_req_cycles", 64'(req_cyc - r0), 64'd255);
        chk("c6_err_set", {63'd0, err}, 64'd1);
        chk("c6_dones", 64'(done_cnt - d0), 64'd1);
        chk("c6_writes", 64'(writes - w0), 64'd0);
        tick(3);
        chk("c6_err_sticky", {63'd0, err}, 64'd1);
        ack = 1'b1;
        do_start(18'h00000, 13'd0);
        chk("c6_err_cleared", {63'd0, err}, 64'd0);
        tick(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
